// File: rtl/ibex_rvfi_ext_snapshot_fifo.sv
// Snapshot FIFO for the rvfi_ext_* side-band: one record per retirement, drained over valid/ready,
// with a saturating mcycle delta and a sticky overflow flag for dropped records.
module ibex_rvfi_ext_snapshot_fifo #(
  parameter int unsigned Depth      = 4,
  parameter int unsigned DeltaWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    rvfi_valid_i,
  input  logic [31:0]             rvfi_ext_mip_i,
  input  logic                    rvfi_ext_nmi_i,
  input  logic                    rvfi_ext_nmi_int_i,
  input  logic                    rvfi_ext_debug_req_i,
  input  logic                    rvfi_ext_debug_mode_i,
  input  logic                    rvfi_ext_rf_wr_suppress_i,
  input  logic                    rvfi_ext_irq_valid_i,
  input  logic [63:0]             rvfi_ext_mcycle_i,

  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [31:0]             out_mip_o,
  output logic                    out_nmi_o,
  output logic                    out_nmi_int_o,
  output logic                    out_debug_req_o,
  output logic                    out_debug_mode_o,
  output logic                    out_rf_wr_suppress_o,
  output logic                    out_irq_valid_o,
  output logic [63:0]             out_mcycle_o,
  output logic [DeltaWidth-1:0]   out_mcycle_delta_o,

  output logic [$clog2(Depth):0]  count_o,
  output logic                    overflow_o,
  input  logic                    clear_overflow_i
);

  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth) + 1;
  localparam int unsigned FlagW = 6;
  localparam logic [63:0] DeltaMax = 64'((65'd1 << DeltaWidth) - 65'd1);

  // Storage array; not reset, outputs are masked while empty.
  logic [31:0]           r_mip_mem   [Depth];
  logic [FlagW-1:0]      r_flag_mem  [Depth];
  logic [63:0]           r_mcyc_mem  [Depth];
  logic [DeltaWidth-1:0] r_delta_mem [Depth];

  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_count;
  logic            r_overflow;
  logic            r_first;
  logic [63:0]     r_prev_mcycle;

  logic [PtrW-1:0]       w_wptr_d, w_rptr_d;
  logic [CntW-1:0]       w_count_d;
  logic                  w_overflow_d;
  logic                  w_empty, w_full;
  logic                  w_pop, w_push, w_drop;
  logic [64:0]           w_diff;
  logic                  w_borrow, w_too_big;
  logic [DeltaWidth-1:0] w_delta;
  logic [FlagW-1:0]      w_flags_in;
  logic [FlagW-1:0]      w_flags_out;

  // Handshake decode
  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == CntW'(Depth));
    w_pop   = ~w_empty & out_ready_i;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside a pop.
    w_push  = rvfi_valid_i & (~w_full | w_pop);
    w_drop  = rvfi_valid_i & w_full & ~w_pop;
  end

  // Saturating delta; the extra bit of the 65-bit subtract catches mcycle going backwards.
  always_comb begin
    w_diff    = {1'b0, rvfi_ext_mcycle_i} - {1'b0, r_prev_mcycle};
    w_borrow  = w_diff[64];
    w_too_big = (w_diff[63:0] > DeltaMax);
    if (r_first) begin
      w_delta = '0;
    end else if (w_borrow || w_too_big) begin
      w_delta = '1;
    end else begin
      w_delta = w_diff[DeltaWidth-1:0];
    end
  end

  always_comb begin
    w_flags_in = {rvfi_ext_nmi_i, rvfi_ext_nmi_int_i, rvfi_ext_debug_req_i,
                  rvfi_ext_debug_mode_i, rvfi_ext_rf_wr_suppress_i, rvfi_ext_irq_valid_i};
  end

  // Next-state for pointers, occupancy and the sticky overflow flag
  always_comb begin
    w_wptr_d     = r_wptr;
    w_rptr_d     = r_rptr;
    w_count_d    = r_count;
    w_overflow_d = r_overflow;

    if (w_push) begin
      w_wptr_d = r_wptr + PtrW'(1);
    end
    if (w_pop) begin
      w_rptr_d = r_rptr + PtrW'(1);
    end

    case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + CntW'(1);
      2'b01:   w_count_d = r_count - CntW'(1);
      default: w_count_d = r_count;
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    if (clear_overflow_i) begin
      w_overflow_d = 1'b0;
    end
    if (w_drop) begin
      w_overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_first       <= 1'b1;
      r_prev_mcycle <= '0;
    end else begin
      r_wptr     <= w_wptr_d;
      r_rptr     <= w_rptr_d;
      r_count    <= w_count_d;
      r_overflow <= w_overflow_d;
      // Dropped records still advance the delta baseline.
      if (rvfi_valid_i) begin
        r_first       <= 1'b0;
        r_prev_mcycle <= rvfi_ext_mcycle_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mip_mem[r_wptr]   <= rvfi_ext_mip_i;
      r_flag_mem[r_wptr]  <= w_flags_in;
      r_mcyc_mem[r_wptr]  <= rvfi_ext_mcycle_i;
      r_delta_mem[r_wptr] <= w_delta;
    end
  end

  // Head record, forced to zero while empty
  always_comb begin
    out_valid_o        = ~w_empty;
    out_mip_o          = '0;
    w_flags_out        = '0;
    out_mcycle_o       = '0;
    out_mcycle_delta_o = '0;
    if (!w_empty) begin
      out_mip_o          = r_mip_mem[r_rptr];
      w_flags_out        = r_flag_mem[r_rptr];
      out_mcycle_o       = r_mcyc_mem[r_rptr];
      out_mcycle_delta_o = r_delta_mem[r_rptr];
    end
    out_nmi_o            = w_flags_out[5];
    out_nmi_int_o        = w_flags_out[4];
    out_debug_req_o      = w_flags_out[3];
    out_debug_mode_o     = w_flags_out[2];
    out_rf_wr_suppress_o = w_flags_out[1];
    out_irq_valid_o      = w_flags_out[0];
    count_o              = r_count;
    overflow_o           = r_overflow;
  end

endmodule

// File: tb/tb_ibex_rvfi_ext_snapshot_fifo.sv
// Bench for ibex_rvfi_ext_snapshot_fifo: directed scenarios then random traffic,
// compared each cycle against a queue-based record model.
module tb_ibex_rvfi_ext_snapshot_fifo;

  localparam int unsigned Depth      = 4;
  localparam int unsigned DeltaWidth = 16;

  typedef struct {
    logic [31:0] mip;
    logic [5:0]  flags;
    logic [63:0] mc;
    logic [15:0] delta;
  } rec_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_v, in_rdy, in_clr;
  logic [31:0] in_mip;
  logic [5:0]  in_flags;
  logic [63:0] in_mc;

  logic        out_valid_o, out_nmi_o, out_nmi_int_o, out_debug_req_o, out_debug_mode_o;
  logic        out_rf_wr_suppress_o, out_irq_valid_o, overflow_o;
  logic [31:0] out_mip_o;
  logic [63:0] out_mcycle_o;
  logic [15:0] out_mcycle_delta_o;
  logic [2:0]  count_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  rec_t        m_q[$];
  logic        m_ovf;
  logic        m_first;
  logic [63:0] m_prev;

  always #5 clk_i = ~clk_i;

  ibex_rvfi_ext_snapshot_fifo #(.Depth(Depth), .DeltaWidth(DeltaWidth)) dut (
    .clk_i                     (clk_i),
    .rst_ni                    (rst_ni),
    .rvfi_valid_i              (in_v),
    .rvfi_ext_mip_i            (in_mip),
    .rvfi_ext_nmi_i            (in_flags[5]),
    .rvfi_ext_nmi_int_i        (in_flags[4]),
    .rvfi_ext_debug_req_i      (in_flags[3]),
    .rvfi_ext_debug_mode_i     (in_flags[2]),
    .rvfi_ext_rf_wr_suppress_i (in_flags[1]),
    .rvfi_ext_irq_valid_i      (in_flags[0]),
    .rvfi_ext_mcycle_i         (in_mc),
    .out_valid_o               (out_valid_o),
    .out_ready_i               (in_rdy),
    .out_mip_o                 (out_mip_o),
    .out_nmi_o                 (out_nmi_o),
    .out_nmi_int_o             (out_nmi_int_o),
    .out_debug_req_o           (out_debug_req_o),
    .out_debug_mode_o          (out_debug_mode_o),
    .out_rf_wr_suppress_o      (out_rf_wr_suppress_o),
    .out_irq_valid_o           (out_irq_valid_o),
    .out_mcycle_o              (out_mcycle_o),
    .out_mcycle_delta_o        (out_mcycle_delta_o),
    .count_o                   (count_o),
    .overflow_o                (overflow_o),
    .clear_overflow_i          (in_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_delta(input logic [63:0] mc);
    if (m_first) return 16'h0;
    if (mc < m_prev) return 16'hFFFF;
    if ((mc - m_prev) > 64'hFFFF) return 16'hFFFF;
    return 16'(mc - m_prev);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovf   = 1'b0;
    m_first = 1'b1;
    m_prev  = '0;
  endtask

  // Applies the current inputs to the model as of the coming rising edge.
  task automatic model_step();
    bit   pop, push, drop;
    rec_t r;
    pop  = (m_q.size() != 0) && in_rdy;
    push = 1'b0;
    drop = 1'b0;
    if (in_v) begin
      r.mip   = in_mip;
      r.flags = in_flags;
      r.mc    = in_mc;
      r.delta = exp_delta(in_mc);
      m_first = 1'b0;
      m_prev  = in_mc;
      if (m_q.size() < Depth || pop) push = 1'b1;
      else drop = 1'b1;
    end
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(r);
    if (in_clr) m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
  endtask

  task automatic check_all(input string tag);
    rec_t h;
    h = '{mip: 32'h0, flags: 6'h0, mc: 64'h0, delta: 16'h0};
    if (m_q.size() != 0) h = m_q[0];
    chk({tag, ".valid"}, 64'(out_valid_o), 64'(m_q.size() != 0));
    chk({tag, ".count"}, 64'(count_o), 64'(m_q.size()));
    chk({tag, ".ovf"}, 64'(overflow_o), 64'(m_ovf));
    chk({tag, ".mip"}, 64'(out_mip_o), 64'(h.mip));
    chk({tag, ".flags"}, 64'({out_nmi_o, out_nmi_int_o, out_debug_req_o, out_debug_mode_o,
                              out_rf_wr_suppress_o, out_irq_valid_o}), 64'(h.flags));
    chk({tag, ".mcycle"}, out_mcycle_o, h.mc);
    chk({tag, ".delta"}, 64'(out_mcycle_delta_o), 64'(h.delta));
  endtask

  task automatic set_in(input logic v, input logic [31:0] mip, input logic [5:0] fl,
                        input logic [63:0] mc, input logic rdy, input logic clr);
    in_v     = v;
    in_mip   = mip;
    in_flags = fl;
    in_mc    = mc;
    in_rdy   = rdy;
    in_clr   = clr;
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk_i);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [63:0] mc;
    rst_ni = 1'b0;
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
    model_reset();
    #12;
    check_all("reset");
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // 1: single push, visible next cycle
    set_in(1'b1, 32'h800, 6'h2A, 64'd100, 1'b0, 1'b0);
    chk("t1.no_bypass", 64'(out_valid_o), 64'd0);
    tick("t1");
    chk("t1.mip_const", 64'(out_mip_o), 64'h800);
    chk("t1.delta_const", 64'(out_mcycle_delta_o), 64'd0);
    chk("t1.count_const", 64'(count_o), 64'd1);

    // 2: streaming with ready high, deltas 0,5,195
    set_in(1'b1, 32'h1, 6'h01, 64'd105, 1'b1, 1'b0);
    tick("t2a");
    chk("t2.delta5", 64'(out_mcycle_delta_o), 64'd5);
    set_in(1'b1, 32'h2, 6'h10, 64'd300, 1'b1, 1'b0);
    tick("t2b");
    chk("t2.delta195", 64'(out_mcycle_delta_o), 64'd195);
    set_in(1'b0, '0, '0, 64'd300, 1'b1, 1'b0);
    tick("t2c");
    chk("t2.drained", 64'(count_o), 64'd0);

    // 3: overfill with ready low, then clear overflow
    for (int i = 0; i <= Depth; i++) begin
      set_in(1'b1, 32'(i + 32'h100), 6'(i), 64'(400 + 10 * i), 1'b0, 1'b0);
      tick("t3fill");
    end
    chk("t3.full", 64'(count_o), 64'(Depth));
    chk("t3.ovf", 64'(overflow_o), 64'd1);
    chk("t3.head_mip", 64'(out_mip_o), 64'h100);
    set_in(1'b0, '0, '0, 64'd500, 1'b0, 1'b1);
    tick("t3clr");
    chk("t3.ovf_cleared", 64'(overflow_o), 64'd0);

    // 4: full with simultaneous push and pop, across pointer wrap
    for (int i = 0; i < 2 * Depth + 1; i++) begin
      set_in(1'b1, 32'(i + 32'h200), 6'(i * 3), 64'(600 + 7 * i), 1'b1, 1'b0);
      tick("t4");
      chk("t4.count", 64'(count_o), 64'(Depth));
      chk("t4.ovf", 64'(overflow_o), 64'd0);
    end
    for (int i = 0; i < Depth; i++) begin
      set_in(1'b0, '0, '0, 64'd0, 1'b1, 1'b0);
      tick("t4drain");
    end

    // 5: saturation on large jump and on mcycle going backwards
    set_in(1'b1, 32'h3, 6'h0, 64'd1000, 1'b1, 1'b0);
    tick("t5a");
    set_in(1'b1, 32'h4, 6'h0, 64'd1000 + 64'h1_0000, 1'b1, 1'b0);
    tick("t5b");
    chk("t5.sat_big", 64'(out_mcycle_delta_o), 64'hFFFF);
    set_in(1'b1, 32'h5, 6'h0, 64'd60, 1'b1, 1'b0);
    tick("t5c");
    set_in(1'b1, 32'h6, 6'h0, 64'd50, 1'b1, 1'b0);
    tick("t5d");
    chk("t5.sat_back", 64'(out_mcycle_delta_o), 64'hFFFF);
    set_in(1'b0, '0, '0, 64'd0, 1'b1, 1'b0);
    tick("t5e");

    // 6: asynchronous reset with three entries held
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'(i + 32'h300), 6'h3F, 64'(2000 + i), 1'b0, 1'b0);
      tick("t6fill");
    end
    chk("t6.count3", 64'(count_o), 64'd3);
    set_in(1'b0, '0, '0, 64'd0, 1'b0, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6.async_valid", 64'(out_valid_o), 64'd0);
    chk("t6.async_count", 64'(count_o), 64'd0);
    model_reset();
    repeat (3) @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check_all("t6post");
    set_in(1'b1, 32'h7, 6'h0, 64'd5000, 1'b0, 1'b0);
    tick("t6push");
    chk("t6.delta_first", 64'(out_mcycle_delta_o), 64'd0);

    // Random traffic
    mc = 64'd5000;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       mc = mc - 64'($urandom_range(1, 50));
        1:       mc = mc + 64'($urandom_range(32'h1_0000, 32'h2_0000));
        2:       mc = mc + 64'h0_FFFF;
        default: mc = mc + 64'($urandom_range(0, 300));
      endcase
      set_in($urandom_range(0, 99) < 60, $urandom, 6'($urandom), mc,
             $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 5);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
